wb4_initiator: RTL and testbench

//  Wishbone B4 classic (non-pipelined) bus initiator.
//  - Turns a simple valid/ready command port into single WB4 read/write cycles.
//  - Returns the result on a valid/ready response port.
//  - Drives the same bus that ram_wb and other WB4 responders attach to.
//  - Used by the loader/debug path and by benches that stimulate a WB4 responder

---
 rtl/wb4_initiator.sv | 172 +++++++++++++++++
 tb/tb_wb4_initiator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wb4_initiator.sv
// Wishbone B4 classic initiator: one valid/ready command becomes one single
// read/write bus cycle, and its result is returned on a valid/ready response port.
module wb4_initiator #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                rsp_tmo,
  output logic                wb_cyc,
  output logic                wb_stb,
  output logic                wb_we,
  output logic [ADDR_W-1:0]   wb_adr,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack,
  input  logic                wb_err
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_tmo_q, rsp_tmo_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          state_d     = BUS;
        end
      end
      BUS: begin
        // ERR beats ACK beats timeout when several coincide.
        if (wb_err) begin
          done      = 1'b1;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b0;
          rsp_dat_d = '0;
        end else if (wb_ack) begin
          done      = 1'b1;
          rsp_err_d = 1'b0;
          rsp_tmo_d = 1'b0;
          rsp_dat_d = we_q ? '0 : wb_dat_i;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          done      = 1'b1;
          rsp_err_d = 1'b1;
          rsp_tmo_d = 1'b1;
          rsp_dat_d = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_tmo_d   = 1'b0;
          rsp_dat_d   = '0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign wb_cyc    = cyc_q;
  assign wb_stb    = stb_q;
  assign wb_we     = we_q;
  assign wb_adr    = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel    = sel_q;
endmodule

// File: tb/tb_wb4_initiator.sv
// Directed bench for wb4_initiator: behavioural WB4 responder with programmable
// wait states / ERR / silence, and a queue of expected responses.
module tb_wb4_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  always #5 clk = ~clk;

  wb4_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  // Responder: mode 0 = ACK, 1 = ACK+ERR together, 2 = silent.
  int          mode, resp_wait, ws_cnt, last_len;
  logic        force_ack, stable_bad, stb_no_cyc;
  logic [68:0] held;

  assign wb_ack = force_ack | (wb_stb && mode != 2 && ws_cnt == resp_wait);
  assign wb_err = wb_stb && mode == 1 && ws_cnt == resp_wait;

  initial begin
    ws_cnt = 0; last_len = 0; stable_bad = 1'b0; stb_no_cyc = 1'b0; held = '0;
  end

  always @(posedge clk) begin
    ws_cnt <= (wb_cyc && wb_stb) ? ws_cnt + 1 : 0;
    if (wb_stb) last_len <= ws_cnt + 1;
    if (wb_stb && ws_cnt == 0) held <= {wb_we, wb_adr, wb_dat_o, wb_sel};
    if (wb_stb && ws_cnt != 0 && held !== {wb_we, wb_adr, wb_dat_o, wb_sel}) stable_bad <= 1'b1;
    if (wb_stb && !wb_cyc) stb_no_cyc <= 1'b1;
  end

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
    int          len;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input string tag, input logic we, input logic [31:0] adr, wdat,
                        input logic [3:0] sel, input logic [31:0] exp_dat,
                        input logic exp_err, exp_tmo, input int exp_len, hold, exp_lat);
    exp_t e, g;
    int n;
    logic [34:0] hd;
    e = '{dat: exp_dat, err: exp_err, tmo: exp_tmo, len: exp_len};
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = wdat; cmd_sel = sel;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    chk({tag, "_bus"}, {wb_cyc, wb_stb, wb_we, wb_adr, wb_sel}, {2'b11, we, adr, sel});
    if (we) chk({tag, "_wdat"}, wb_dat_o, wdat);
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    if (exp_lat > 0) chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_cyc_low"}, {wb_cyc, wb_stb}, 2'b00);
    g = sb.pop_front();
    chk({tag, "_dat"}, rsp_dat, g.dat);
    chk({tag, "_err_tmo"}, {rsp_err, rsp_tmo}, {g.err, g.tmo});
    chk({tag, "_stb_len"}, last_len, g.len);
    chk({tag, "_stable"}, {stable_bad, stb_no_cyc}, 2'b00);
    hd = {rsp_valid, rsp_dat, rsp_err, rsp_tmo};
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'hBAD0_0000;
      @(negedge clk);
      chk({tag, "_hold_rsp"}, {rsp_valid, rsp_dat, rsp_err, rsp_tmo}, hd);
      chk({tag, "_hold_ready_cyc"}, {cmd_ready, wb_cyc}, 2'b00);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_taken"}, {rsp_valid, rsp_err, rsp_tmo, cmd_ready, wb_cyc}, 5'b00010);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_dat_i = '0; mode = 0; resp_wait = 0; force_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {cmd_ready, rsp_valid, rsp_err, rsp_tmo, wb_cyc, wb_stb}, 6'b100000);
    chk("reset_rdat", rsp_dat, 0);
    rst = 1'b0;

    // 1: read, ACK in first STB cycle
    mode = 0; resp_wait = 0; wb_dat_i = 32'hDEADBEEF;
    do_txn("t1_read", 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1, 0, 2);

    // 2: write with 3 wait states; read data on the bus must not leak into rsp_dat
    resp_wait = 3; wb_dat_i = 32'hCAFE_F00D;
    do_txn("t2_write", 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 1'b0, 4, 0, 5);

    // 3: ACK and ERR together
    mode = 1; resp_wait = 1; wb_dat_i = 32'h5555_AAAA;
    do_txn("t3_err", 1'b0, 32'h0000_0030, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 2, 0, 3);

    // 4: silent responder -> timeout after 8 STB cycles, later ACK ignored
    mode = 2;
    do_txn("t4_tmo", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h0, 1'b1, 1'b1, 8, 0, 9);
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_late_ack", {rsp_valid, cmd_ready, wb_cyc, rsp_err}, 4'b0100);
    end
    force_ack = 1'b0;

    // 5: response back-pressure with a command waiting
    mode = 0; resp_wait = 2; wb_dat_i = 32'h0BAD_CAFE;
    do_txn("t5_hold", 1'b0, 32'h0000_0050, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0, 1'b0, 3, 5, 4);

    // 6: reset in the middle of a bus cycle
    mode = 2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h0000_0060; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t6_in_bus", {wb_cyc, wb_stb}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_edge", {wb_cyc, wb_stb, rsp_valid, cmd_ready}, 4'b0001);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_no_rsp", {rsp_valid, wb_cyc, cmd_ready}, 3'b001);
    mode = 0; resp_wait = 1; wb_dat_i = 32'h600D_0001;
    do_txn("t6_after", 1'b0, 32'h0000_0070, 32'h0, 4'hF, 32'h600D_0001, 1'b0, 1'b0, 2, 0, 3);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
